dmem_resp: RTL and testbench
============================

DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width (RAM depth 2^ADDR_W words of 32 bits).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port dm_addr  input  32  byte address from the MEM stage.
REQ-005 SHALL have port dm_wen  input  4  byte-lane write enables; bit n controls dm_wdata[8n+7:8n].
REQ-006 SHALL have port dm_wdata  input  32  lane-aligned store data.
REQ-007 SHALL have port dm_rdata  output  32  registered read data for the address presented in the previous cycle.
REQ-008 SHALL have port dm_align_err  output  1  registered flag for a misaligned store pattern.
REQ-009 SHALL have port timer_irq  output  1  level interrupt from the MMIO timer.

Function
REQ-010 SHALL index RAM with dm_addr[ADDR_W+1:2]; higher RAM-region address bits are ignored (aliasing).
REQ-011 SHALL sample dm_addr every cycle with no enable; dm_rdata in cycle N+1 reflects address at edge N (1-cycle read latency).
REQ-012 SHALL write only lanes with dm_wen bit set; other lanes of the word keep their value.
REQ-013 SHALL return old data on read-during-write to the same word (read-first).
REQ-014 SHALL set dm_align_err for one cycle after an edge where dm_wen is 4'b1111 with dm_addr[1:0]!=0, or 4'b0011/4'b1100 with dm_addr[0]=1; the store SHALL still be performed as lanes indicate.
REQ-015 SHALL treat dm_wen values other than 0000, single-bit, 0011, 1100, 1111 as an error (dm_align_err=1 next cycle), and write nothing.
REQ-016 SHALL be stateless apart from RAM and registered outputs; no handshake, every cycle accepted.

Reset
REQ-017 SHALL clear dm_rdata, dm_align_err, timer_irq to 0 asynchronously on reset.
REQ-018 SHALL NOT clear RAM contents on reset.
REQ-019 SHALL ignore dm_wen while reset is asserted; first write accepted on the first edge after deassertion.
REQ-020 SHALL, with the timer compiled in, reset COUNT to 0, COMPARE to 32'hFFFF_FFFF, PENDING to 0.

Configuration
REQ-021 SHALL compile the MMIO timer only when macro DMEM_MMIO_TIMER_EN is defined.
REQ-022 With DMEM_MMIO_TIMER_EN: addresses with dm_addr[31:12]==20'hBFAFF decode to MMIO, never touching RAM.
REQ-023 MMIO 0xBFAFF000 COUNT: read-only, increments by 1 every cycle, wraps 32'hFFFF_FFFF to 0; writes ignored.
REQ-024 MMIO 0xBFAFF004 COMPARE: read/write with per-lane dm_wen.
REQ-025 MMIO 0xBFAFF008 STATUS: bit0 = PENDING, bits 31:1 read 0; write with dm_wen[0]=1 and dm_wdata[0]=1 clears PENDING.
REQ-026 PENDING SHALL set on the edge where COUNT==COMPARE; simultaneous set and clear SHALL leave PENDING=1.
REQ-027 timer_irq SHALL equal PENDING; other MMIO offsets read 0, writes ignored.
REQ-028 MMIO reads SHALL have the same 1-cycle latency as RAM reads, returning the register value before that edge's update.
REQ-029 Without DMEM_MMIO_TIMER_EN: all addresses map to RAM per REQ-010, timer_irq tied 0, no timer registers.

Verification
REQ-030 Write 0x11223344 to 0x0000_0010 wen=1111, next cycle read 0x10 -> dm_rdata=0x11223344 one cycle after address presented.
REQ-031 Then wen=0100 addr 0x12 wdata 0x00AB0000, read 0x10 -> 0x11AB3344; wen=1100 addr 0x12 wdata 0xBEEF0000 -> 0xBEEF3344.
REQ-032 Write 0xDEADBEEF and read same word 0x20 in one cycle (prior 0x0) -> dm_rdata=0x0, next read -> 0xDEADBEEF.
REQ-033 wen=1111 addr 0x22 -> dm_align_err=1 exactly one cycle; wen=0101 -> dm_align_err=1 and RAM word unchanged.
REQ-034 (timer on) reset, write COMPARE=5 -> timer_irq rises when COUNT==5 edge passes; STATUS read=1; write STATUS=1 -> timer_irq=0 next cycle.
REQ-035 Assert reset mid-write burst -> outputs 0 immediately, RAM keeps pre-reset words, COUNT restarts at 0.

Source files
------------

// File: rtl/dmem_resp.sv
// Data-memory response stage: byte-lane RAM with registered read data and store-pattern checks.
// Optional MMIO timer (COUNT/COMPARE/STATUS) is compiled in with DMEM_MMIO_TIMER_EN.
module dmem_resp #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dm_addr,
    input  logic [3:0]  dm_wen,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_align_err,
    output logic        timer_irq
);

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] idx;
    logic              wen_legal;
    logic              misalign;
    logic              is_mmio;
    logic              ram_we;
    logic [31:0]       mmio_rd;
    logic [31:0]       rdata_q;
    logic              align_err_q;
    logic              unused_addr;

    assign idx         = dm_addr[ADDR_W+1:2];
    assign unused_addr = ^dm_addr;

    always_comb begin
        wen_legal = 1'b0;
        misalign  = 1'b0;
        case (dm_wen)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: wen_legal = 1'b1;
            4'b0011, 4'b1100: begin
                wen_legal = 1'b1;
                misalign  = dm_addr[0];
            end
            4'b1111: begin
                wen_legal = 1'b1;
                misalign  = |dm_addr[1:0];
            end
            default: wen_legal = 1'b0;
        endcase
    end

    assign ram_we = wen_legal && !is_mmio;

    // RAM is never reset; writes are simply masked while reset is held.
    always_ff @(posedge clk) begin
        if (!reset && ram_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (dm_wen[i]) mem[idx][8*i +: 8] <= dm_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q     <= '0;
            align_err_q <= 1'b0;
        end else begin
            rdata_q     <= is_mmio ? mmio_rd : mem[idx];
            align_err_q <= !wen_legal || misalign;
        end
    end

    assign dm_rdata     = rdata_q;
    assign dm_align_err = align_err_q;

`ifdef DMEM_MMIO_TIMER_EN
    logic [31:0] count_q;
    logic [31:0] compare_q, compare_d;
    logic        pending_q, pending_d;
    logic [9:0]  off;
    logic        mmio_we;
    logic        status_clr;

    assign is_mmio    = (dm_addr[31:12] == 20'hBFAFF);
    assign off        = dm_addr[11:2];
    assign mmio_we    = is_mmio && wen_legal;
    assign status_clr = mmio_we && (off == 10'd2) && dm_wen[0] && dm_wdata[0];

    always_comb begin
        compare_d = compare_q;
        if (mmio_we && off == 10'd1) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (dm_wen[i]) compare_d[8*i +: 8] = dm_wdata[8*i +: 8];
            end
        end
        // A match on the same edge as a clear wins, so no interrupt is lost.
        pending_d = (count_q == compare_q) || (pending_q && !status_clr);
        case (off)
            10'd0:   mmio_rd = count_q;
            10'd1:   mmio_rd = compare_q;
            10'd2:   mmio_rd = {31'b0, pending_q};
            default: mmio_rd = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            compare_q <= '1;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_q + 32'd1;
            compare_q <= compare_d;
            pending_q <= pending_d;
        end
    end

    assign timer_irq = pending_q;
`else
    assign is_mmio   = 1'b0;
    assign mmio_rd   = '0;
    assign timer_irq = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp; timer checks are included when DMEM_MMIO_TIMER_EN is defined.
module tb_dmem_resp;

    logic        clk;
    logic        reset;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wen;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_align_err;
    logic        timer_irq;

    int checks   = 0;
    int failures = 0;

    dmem_resp #(.ADDR_W(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .dm_addr      (dm_addr),
        .dm_wen       (dm_wen),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata),
        .dm_align_err (dm_align_err),
        .timer_irq    (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Present one access, then sample 1 time unit after the capturing edge.
    task automatic cyc(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        dm_addr  = a;
        dm_wen   = w;
        dm_wdata = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        dm_addr  = '0;
        dm_wen   = '0;
        dm_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", dm_rdata, 32'h0);
        check("rst_err", {31'b0, dm_align_err}, 32'h0);
        check("rst_irq", {31'b0, timer_irq}, 32'h0);
        reset = 1'b0;

`ifdef DMEM_MMIO_TIMER_EN
        cyc(32'hBFAFF000, 4'b0000, 32'h0);
        check("count_first", dm_rdata, 32'h0);
        cyc(32'hBFAFF004, 4'b1111, 32'h5);
        repeat (3) cyc(32'h0, 4'b0000, 32'h0);
        check("irq_before_match", {31'b0, timer_irq}, 32'h0);
        cyc(32'h0, 4'b0000, 32'h0);
        check("irq_after_match", {31'b0, timer_irq}, 32'h1);
        cyc(32'hBFAFF008, 4'b0000, 32'h0);
        check("status_read", dm_rdata, 32'h1);
        cyc(32'hBFAFF004, 4'b0000, 32'h0);
        check("compare_read", dm_rdata, 32'h5);
        cyc(32'hBFAFF008, 4'b0001, 32'h1);
        check("irq_cleared", {31'b0, timer_irq}, 32'h0);
        cyc(32'hBFAFF000, 4'b0000, 32'h0);
        check("count_9", dm_rdata, 32'd9);
        cyc(32'hBFAFF100, 4'b0000, 32'h0);
        check("mmio_other", dm_rdata, 32'h0);
`else
        check("irq_tied", {31'b0, timer_irq}, 32'h0);
`endif

        cyc(32'h10, 4'b1111, 32'h11223344);
        check("wr_err", {31'b0, dm_align_err}, 32'h0);
        cyc(32'h10, 4'b0000, 32'h0);
        check("rd_full", dm_rdata, 32'h11223344);

        cyc(32'h12, 4'b0100, 32'h00AB0000);
        cyc(32'h10, 4'b0000, 32'h0);
        check("rd_lane2", dm_rdata, 32'h11AB3344);
        cyc(32'h12, 4'b1100, 32'hBEEF0000);
        check("half_hi_ok", {31'b0, dm_align_err}, 32'h0);
        cyc(32'h10, 4'b0000, 32'h0);
        check("rd_half_hi", dm_rdata, 32'hBEEF3344);
        cyc(32'h1010, 4'b0000, 32'h0);
        check("alias", dm_rdata, 32'hBEEF3344);

`ifdef DMEM_MMIO_TIMER_EN
        cyc(32'hBFAFF010, 4'b1111, 32'h0);
        cyc(32'h10, 4'b0000, 32'h0);
        check("mmio_no_ram", dm_rdata, 32'hBEEF3344);
`endif

        cyc(32'h20, 4'b1111, 32'h0);
        cyc(32'h20, 4'b1111, 32'hDEADBEEF);
        check("rdw_old", dm_rdata, 32'h0);
        cyc(32'h20, 4'b0000, 32'h0);
        check("rdw_new", dm_rdata, 32'hDEADBEEF);

        cyc(32'h22, 4'b1111, 32'h12345678);
        check("mis_word_err", {31'b0, dm_align_err}, 32'h1);
        cyc(32'h20, 4'b0000, 32'h0);
        check("mis_err_1cyc", {31'b0, dm_align_err}, 32'h0);
        check("mis_word_wr", dm_rdata, 32'h12345678);
        cyc(32'h20, 4'b0101, 32'hFFFFFFFF);
        check("bad_wen_err", {31'b0, dm_align_err}, 32'h1);
        cyc(32'h20, 4'b0000, 32'h0);
        check("bad_wen_nowr", dm_rdata, 32'h12345678);
        cyc(32'h21, 4'b0011, 32'h0000AAAA);
        check("mis_half_err", {31'b0, dm_align_err}, 32'h1);
        cyc(32'h23, 4'b1000, 32'h99000000);
        check("byte_odd_ok", {31'b0, dm_align_err}, 32'h0);
        cyc(32'h20, 4'b0000, 32'h0);
        check("mis_half_wr", dm_rdata, 32'h9934AAAA);

        cyc(32'h40, 4'b1111, 32'hCAFE0001);
        cyc(32'h44, 4'b1111, 32'hCAFE0002);
        cyc(32'h40, 4'b1010, 32'h0);
        check("pre_rst_err", {31'b0, dm_align_err}, 32'h1);
        check("pre_rst_rd", dm_rdata, 32'hCAFE0001);
        dm_addr  = 32'h40;
        dm_wen   = 4'b1111;
        dm_wdata = 32'hFFFFFFFF;
        #2;
        reset = 1'b1;
        #1;
        check("async_rdata", dm_rdata, 32'h0);
        check("async_err", {31'b0, dm_align_err}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
`ifdef DMEM_MMIO_TIMER_EN
        cyc(32'hBFAFF000, 4'b0000, 32'h0);
        check("count_restart", dm_rdata, 32'h0);
`endif
        cyc(32'h40, 4'b0000, 32'h0);
        check("ram_kept_40", dm_rdata, 32'hCAFE0001);
        cyc(32'h44, 4'b0000, 32'h0);
        check("ram_kept_44", dm_rdata, 32'hCAFE0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
